// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract M, restore on borrow.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_a_sh;
  logic [WIDTH:0] w_trial;
  logic           w_borrow;

  // A stays below M between iterations, so its top bit is always shifted out as zero.
  assign w_a_sh   = (i_a << 1) | {{WIDTH{1'b0}}, i_q[WIDTH-1]};
  assign w_trial  = w_a_sh - {1'b0, i_m};
  assign w_borrow = w_trial[WIDTH];

  assign o_a = w_borrow ? w_a_sh : w_trial;
  assign o_q = {i_q[WIDTH-2:0], ~w_borrow};

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for the restoring divider: owns A/Q/M/cnt, runs WIDTH iterations and publishes results.
// Handshake: i_start is sampled only in IDLE; o_busy is high whenever not IDLE; o_done pulses one cycle with results.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero,
  output logic [1:0]       o_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH:0]   w_a_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_accept;
  logic             w_zero_div;
  logic             w_last;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_a (r_a),
    .i_q (r_q),
    .i_m (r_m),
    .o_a (w_a_nxt),
    .o_q (w_q_nxt)
  );

  assign w_accept   = (r_state == IDLE) && i_start;
  assign w_zero_div = (i_divisor == '0);
  assign w_last     = (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_zero_div ? DONE : ITER;
        end
      end
      ITER: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Results are written only on the completing edge, so they hold between operations.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a           <= '0;
      r_q           <= '0;
      r_m           <= '0;
      r_cnt         <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= '0;
            r_q   <= i_dividend;
            r_m   <= i_divisor;
            r_cnt <= CW'(WIDTH - 1);
            if (w_zero_div) begin
              r_quotient    <= '1;
              r_remainder   <= i_dividend;
              r_div_by_zero <= 1'b1;
            end
          end
        end
        ITER: begin
          r_a <= w_a_nxt;
          r_q <= w_q_nxt;
          if (w_last) begin
            r_quotient    <= w_q_nxt;
            r_remainder   <= w_a_nxt[WIDTH-1:0];
            r_div_by_zero <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy        = (r_state != IDLE);
  assign o_done        = (r_state == DONE);
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;
  assign o_state       = r_state;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: a behavioural model predicts results and done timing from / and %.
module tb_div_seq_ctrl;

  localparam int W = 8;
  localparam int RW = 2 * W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   state;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (div_by_zero),
    .o_state       (state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state: expected {div_by_zero, quotient, remainder} per completion
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] held = '0;
  int            busy_until = -1;
  bit            mon_en = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the operation accepted at edge e completes at edge e+W (or e for /0).
  task automatic model_accept(input logic [W-1:0] a, input logic [W-1:0] b, input int e);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == 0) begin
      busy_until = e;
      exp_q.push_back({1'b1, {W{1'b1}}, a});
    end else begin
      q = W'(int'(a) / int'(b));
      r = W'(int'(a) % int'(b));
      busy_until = e + W;
      exp_q.push_back({1'b0, q, r});
    end
  endtask

  // driver: one clock cycle with the given inputs
  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int e;
    @(negedge clk);
    start    = s;
    dividend = a;
    divisor  = b;
    e = cyc + 1;
    @(posedge clk);
    if (s && rst_n && (e - 1 > busy_until)) model_accept(a, b, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, W'($urandom), W'($urandom));
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
    drive(1'b1, a, b);
    while (cyc <= busy_until + 1) drive(1'b0, W'($urandom), W'($urandom));
  endtask

  // monitor: compares outputs against the model every cycle, pops on done
  always @(negedge clk) begin
    if (mon_en) begin
      chk("done", 32'(done), 32'(cyc == busy_until));
      chk("busy", 32'(busy), 32'(cyc <= busy_until));
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(1), 32'(0));
        end else begin
          held = exp_q.pop_front();
        end
      end
      chk("result", 32'({div_by_zero, quotient, remainder}), 32'(held));
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_res", 32'({div_by_zero, quotient, remainder}), 32'(0));
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    op(8'd100, 8'd7);
    idle(3);
    op(8'd255, 8'd1);
    idle(2);
    op(8'd5, 8'd9);
    idle(4);
    op(8'd200, 8'd0);
    op(8'd9, 8'd3);
    idle(2);

    // start during ITER must be ignored
    drive(1'b1, 8'd100, 8'd7);
    idle(2);
    drive(1'b1, 8'd50, 8'd5);
    idle(10);

    // asynchronous reset after E4 of an operation
    drive(1'b1, 8'd100, 8'd7);
    idle(4);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    busy_until = -1;
    held = '0;
    #1;
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_res", 32'({div_by_zero, quotient, remainder}), 32'(0));
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    op(8'd50, 8'd6);
    chk("after_reset_res", 32'({div_by_zero, quotient, remainder}), 32'({1'b0, 8'd8, 8'd2}));

    // start held high: one operation every W+2 cycles
    for (int i = 0; i < 30; i++) drive(1'b1, 8'd77, 8'd10);
    idle(W + 3);

    // randomized operations with random gaps and occasional divide-by-zero
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      drive(1'b1, a, b);
      idle($urandom_range(0, W + 3));
    end
    while (cyc <= busy_until + 2) idle(1);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Sequential restoring-division controller for the project's divider. It accepts a dividend/divisor pair on a start pulse and steps a shift/trial-subtract datapath once per clock for WIDTH iterations. It then publishes quotient and remainder with a one-cycle done strobe. It sits between the operand source (switch/test logic) and the result display, and owns all sequencing of the A/Q/M registers.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low; one clock domain only
- start  in  1  request; sampled only in IDLE
- dividend  in  WIDTH  unsigned dividend, captured on accepted start
- divisor  in  WIDTH  unsigned divisor, captured on accepted start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle strobe, results valid
- quotient  out  WIDTH  last result, held until next completion
- remainder  out  WIDTH  last result, held until next completion
- div_by_zero  out  1  flag for last result, held with quotient/remainder

## Operation
- FSM states: IDLE, ITER, DONE.
- IDLE: if start=1 at edge, capture M=divisor, Q=dividend, A=0 (WIDTH+1 bits), cnt=WIDTH-1.
  - divisor≠0 → ITER.
  - divisor=0 → DONE directly. quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1 are written at the same edge.
- ITER, each edge:
  - {A,Q} shifted left 1; T = A_shifted − {0,M}.
  - T[WIDTH]=0 → A=T, Q[0]=1.
  - T[WIDTH]=1 → A=A_shifted (restore), Q[0]=0.
  - cnt=0 → DONE, and at that edge quotient←new Q, remainder←new A[WIDTH-1:0], div_by_zero←0. Otherwise cnt−1.
- DONE: done=1 for exactly this cycle, then IDLE unconditionally. start is ignored in DONE.
- start while busy (ITER/DONE): ignored, no effect on operands or state.
- Arithmetic: all unsigned. A is WIDTH+1 bits so the trial-subtract sign bit is exact. cnt is $clog2(WIDTH) bits with no wrap: it is only decremented while >0.
- Reset (rst=0, any time including mid-ITER): state=IDLE, A=Q=M=0, cnt=0, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. The in-flight operation is discarded; no done strobe is produced.

## Timing
- Edge E0 accepts start. busy is high from E0 until edge E(WIDTH+1).
- Normal case: iterations occur at E1..E_WIDTH. done and new results are visible in the cycle after E_WIDTH (WIDTH=8: after E8). IDLE resumes at E(WIDTH+1).
- Divide-by-zero: done and results are visible in the cycle after E0. IDLE resumes at E1.
- Earliest next accept is E(WIDTH+2), i.e. start held high gives one operation per WIDTH+2 cycles.
- quotient/remainder/div_by_zero change only at the completing edge; they are stable at all other times.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package div_pkg:
  - state typedef (IDLE, ITER, DONE) with 2-bit encoding.
  - default WIDTH localparam.
- One sub-module, div_step: combinational single iteration, taking A, Q, M and returning next A and next Q. It is instantiated once, and the controller registers its outputs.
- Registers use the team's async-active-low flop style. The existing plain dff is not reused, because it has no reset.

## Test plan
- 100/7, WIDTH=8, start pulse at E0 → done only in the cycle after E8; quotient=14, remainder=2, div_by_zero=0; busy low after E9.
- 255/1 and 5/9 → (255,0) and (0,5); results hold unchanged until the next done.
- 200/0 → done in the cycle after E0; quotient=255, remainder=200, div_by_zero=1; then 9/3 → (3,0) with div_by_zero cleared.
- start pulsed at E3 during 100/7 with different operands → ignored; the result is still (14,2) at the original time.
- rst low after E4 of 100/7 → all outputs 0 immediately (asynchronous), no done. After release, 50/6 → (8,2).
- start held high for 30 cycles with 77/10 → done pulses spaced exactly 10 cycles apart, each (7,7).
